// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Dequeue-side consumer for the team fifo. Pops one WIDTH-bit word over a
//   valid/ready handshake and sends it as WIDTH/8 back-to-back 8N1 UART
//   frames, least-significant byte first, each bit LSB first.
//
// Ports
//   clk         system clock, all state changes on posedge
//   rst         synchronous, active-high reset
//   in_data     word to transmit, sampled only on the handshake edge
//   in_valid    producer has a word (fifo deq_valid)
//   in_ready    block can accept a word (fifo deq_ready)
//   serial_out  UART TX line, idle high, driven from a register
//   busy        high while a word is being transmitted
//
// Handshake: a word transfers on the posedge where in_valid && in_ready.
// in_ready is a function of state and rst only, never of in_valid, so there
// is no combinational path from in_valid to in_ready. The producer keeps
// in_valid/in_data stable until the transfer; the block never drops or
// duplicates a word, and in_valid while busy is simply not consumed.
module fifo_uart_tx #(
  parameter int WIDTH      = 32,
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             busy
);

  localparam int BYTES            = WIDTH / 8;
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int BYTE_W           = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] byte_idx;
  logic [WIDTH-1:0]  word_q;
  logic              serial_q;

  // Bit period ends on the last cycle of the symbol counter.
  logic bit_done;
  assign bit_done = (cnt == CNT_LAST);

  assign in_ready   = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign serial_out = serial_q;

  // word_q is used as a right-shift register: bit 0 is always the next data
  // bit to send. After the eighth shift of a frame the following byte sits
  // in [7:0], so no byte/bit index is needed to select the output bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      serial_q <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          serial_q <= 1'b1;
          // in_ready is implied here: state is IDLE and rst is low.
          if (in_valid) begin
            word_q   <= in_data;
            state    <= START;
            serial_q <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        START: begin
          if (bit_done) begin
            cnt      <= '0;
            state    <= DATA;
            serial_q <= word_q[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt    <= '0;
            word_q <= word_q >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx  <= '0;
              state    <= STOP;
              serial_q <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              serial_q <= word_q[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (byte_idx == BYTE_LAST) begin
              // Word finished; IDLE lands exactly BYTES*10 bit times after
              // the accepting edge.
              byte_idx <= '0;
              state    <= IDLE;
              serial_q <= 1'b1;
            end else begin
              // Next start bit directly follows this stop bit, no gap.
              byte_idx <= byte_idx + BYTE_W'(1);
              state    <= START;
              serial_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx with CLOCK_FREQ=1000, BAUD_RATE=100
//   (10 clocks per bit) and WIDTH=32. Expected bytes go into exp_q when a
//   word is driven; a line decoder samples serial_out mid-bit and pops and
//   compares each decoded byte. A small queue model stands in for the
//   upstream fifo (depth 8) in the back-to-back run.
module tb_fifo_uart_tx;

  localparam int WIDTH    = 32;
  localparam int BYTES    = 4;
  localparam int WORD_CYC = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              serial_out;
  logic              busy;

  fifo_uart_tx #(
    .WIDTH      (WIDTH),
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < BYTES; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  // ---------------- line decoder ----------------
  // Cycle 0 is the first negedge where the line is seen low; bits are
  // sampled at cycle 5 + 10*n (start, b0..b7, stop).
  int         cyc        = 0;
  logic       dec_active = 1'b0;
  int         dec_cnt    = 0;
  logic [7:0] dec_byte   = '0;
  logic [7:0] exp_byte;
  bit         gap_chk    = 1'b0;
  int         gap_frames = 0;
  int         last_start = 0;

  always @(negedge clk) begin
    cyc++;
    if (dec_active && !busy) begin
      // Frame cut short by reset.
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (serial_out === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        if (gap_chk) begin
          // Frames within a word start 100 apart; a new word adds 1 idle cycle.
          if (gap_frames > 0)
            check("frame_spacing", 32'(cyc - last_start), (gap_frames % 4 == 0) ? 32'd101 : 32'd100);
          last_start = cyc;
          gap_frames++;
        end
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == 5) begin
        check("start_bit", {31'd0, serial_out}, 32'd0);
      end else if (dec_cnt >= 15 && dec_cnt <= 85 && (dec_cnt - 5) % 10 == 0) begin
        dec_byte[(dec_cnt - 15) / 10] = serial_out;
      end else if (dec_cnt == 95) begin
        check("stop_bit", {31'd0, serial_out}, 32'd1);
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          check("data_byte", {24'd0, dec_byte}, {24'd0, exp_byte});
        end
        dec_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present w, wait for the accepting edge, then on the following negedge
  // drive in_valid=keep, in_data=nxt (nxt is queued as expected when kept).
  task automatic send_word(input logic [31:0] w, input bit keep, input logic [31:0] nxt);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    push_word(w);
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", {31'd0, t < 2000}, 32'd1);
    @(negedge clk);
    in_valid = keep;
    in_data  = nxt;
    if (keep) push_word(nxt);
  endtask

  // Count negedges with in_ready low (and busy high) until in_ready returns.
  task automatic measure(output int lo, output int by);
    lo = 0;
    by = 0;
    while (!in_ready && lo < 2000) begin
      lo++;
      if (busy) by++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || dec_active || !in_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", {31'd0, t < 5000}, 32'd1);
  endtask

  // Upstream fifo model: depth 8, enqueue 50 words at full rate.
  task automatic fifo_run();
    logic [31:0] fq[$];
    logic [31:0] head;
    int sent = 0;
    int t    = 0;
    while ((sent < 50 || fq.size() > 0) && t < 30000) begin
      @(negedge clk);
      t++;
      if (sent < 50 && fq.size() < 8) begin
        fq.push_back(32'(1000 + sent));
        push_word(32'(1000 + sent));
        sent++;
      end
      in_valid = (fq.size() > 0);
      in_data  = (fq.size() > 0) ? fq[0] : '0;
      if (in_valid && in_ready) head = fq.pop_front();
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("fifo_timeout", {31'd0, t < 30000}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lo;
    int by;
    int bad;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held 2 cycles.
    repeat (2) begin
      @(negedge clk);
      check("rst_serial", {31'd0, serial_out}, 32'd1);
      check("rst_busy",   {31'd0, busy},       32'd0);
      check("rst_ready",  {31'd0, in_ready},   32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Idle with in_valid low: nothing moves.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    check("idle_stable", 32'(bad), 32'd0);

    // Single word.
    send_word(32'h0000_03E8, 1'b0, 32'h0);
    measure(lo, by);
    check("ready_low_cycles", 32'(lo), 32'(WORD_CYC));
    check("busy_cycles",      32'(by), 32'(WORD_CYC));
    wait_drain();

    // Data hold: in_data changes right after the handshake.
    send_word(32'h0000_03E8, 1'b0, 32'hFFFF_FFFF);
    measure(lo, by);
    check("hold_ready_low", 32'(lo), 32'(WORD_CYC));
    wait_drain();

    // Busy ignore: second word held valid during the first word.
    send_word(32'hA5C3_0F1E, 1'b1, 32'h5A3C_F0E1);
    measure(lo, by);
    check("ignore_ready_low", 32'(lo), 32'(WORD_CYC));
    check("ignore_busy",      32'(by), 32'(WORD_CYC));
    @(negedge clk);
    in_valid = 1'b0;
    check("second_accepted", {31'd0, busy}, 32'd1);
    measure(lo, by);
    check("second_ready_low", 32'(lo), 32'(WORD_CYC));
    wait_drain();

    // Reset 55 cycles into a word, then a clean word.
    send_word(32'hDEAD_BEEF, 1'b0, 32'h0);
    repeat (54) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_serial", {31'd0, serial_out}, 32'd1);
    check("midrst_busy",   {31'd0, busy},       32'd0);
    check("midrst_ready",  {31'd0, in_ready},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    send_word(32'h1234_5678, 1'b0, 32'h0);
    measure(lo, by);
    check("post_rst_ready_low", 32'(lo), 32'(WORD_CYC));
    wait_drain();

    // Back-to-back through the fifo model.
    gap_frames = 0;
    gap_chk    = 1'b1;
    fifo_run();
    wait_drain();
    gap_chk = 1'b0;
    check("b2b_frames", 32'(gap_frames), 32'd200);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
